led_test_pattern_gen: RTL and testbench

//  Parametrised LED-PHY stimulus source, the successor of the fixed-pattern test block.
//  - Emits a one-cycle enable strobe every PERIOD clocks.
//  - Drives a DATA_W-bit frame chosen by a runtime mode: fixed, alternating, walking-one, ramp, LFSR, blink.
//  - Sits directly in front of the LED PHY (enable/data_in), for waveform checks and on-board brightness tests.

---
 rtl/led_test_pattern_gen.sv | 180 ++++++++++++++++++
 tb/tb_led_test_pattern_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_test_pattern_gen.sv
// LED-PHY stimulus source: a one-cycle enable strobe every PERIOD clocks, paired with
// a DATA_W-bit frame whose pattern (fixed/alternate/walk/ramp/LFSR/blink) is latched at run start.
module led_test_pattern_gen #(
  parameter int                DATA_W        = 128,
  parameter int                PERIOD        = 25000,
  parameter logic [DATA_W-1:0] FIXED_PATTERN = {(DATA_W/32){32'h5555_5555}},
  parameter logic [31:0]       LFSR_SEED     = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [2:0]        mode,
  output logic              enable,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int            LANES     = DATA_W / 32;
  localparam int            CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_q, frame_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Right-shifting Galois form: the bit shifted out decides whether the taps are folded in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) begin
      r = r ^ LFSR_TAPS;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] seed_of(input logic [2:0] m);
    logic [DATA_W-1:0] r;
    case (m)
      3'd1:    r = {LANES{32'h5555_5555}};
      3'd2:    r = {{(DATA_W-1){1'b0}}, 1'b1};
      3'd3:    r = {DATA_W{1'b0}};
      3'd4:    r = {LANES{LFSR_SEED}};
      3'd5:    r = {DATA_W{1'b1}};
      default: r = FIXED_PATTERN;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] next_of(input logic [2:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      3'd1, 3'd5: r = ~d;
      3'd2:       r = {d[DATA_W-2:0], d[DATA_W-1]};
      3'd3: begin
        for (int i = 0; i < LANES; i++) begin
          r[32*i +: 32] = d[32*i +: 32] + 32'd1;
        end
      end
      3'd4:       r = {LANES{lfsr_step(d[31:0])}};
      default:    r = d;
    endcase
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
        else     state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (run) state_d = ST_RUN;
        else     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the counter, strobe, frame count and frame data
  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    busy_d   = busy_q;
    frame_d  = frame_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          mode_d  = mode;
          cnt_d   = {CW{1'b0}};
          frame_d = 16'd0;
          data_d  = seed_of(mode);
          busy_d  = 1'b1;
        end else begin
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!run) begin
          // Leaving RUN suppresses any pending data advance; data and frame count hold.
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b0;
          enable_d = 1'b0;
        end else begin
          busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = {CW{1'b0}};
            enable_d = 1'b1;
            frame_d  = frame_q + 16'd1;
          end else begin
            cnt_d    = cnt_q + CW'(1);
            enable_d = 1'b0;
          end
          if (enable_q) begin
            data_d = next_of(mode_q, data_q);
          end else begin
            data_d = data_q;
          end
        end
      end
      default: begin
        cnt_d    = {CW{1'b0}};
        busy_d   = 1'b0;
        enable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 3'd0;
      cnt_q    <= {CW{1'b0}};
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      frame_q  <= 16'd0;
      data_q   <= FIXED_PATTERN;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
    end
  end

  assign enable    = enable_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_q;
  assign data_in   = data_q;

endmodule

// File: tb/tb_led_test_pattern_gen.sv
// Self-checking bench for led_test_pattern_gen: an arithmetic model (frame index from elapsed
// cycles) is compared every cycle, plus hand-computed literal expectations at key points.
module tb_led_test_pattern_gen;
  localparam int              W   = 64;
  localparam int              P   = 8;
  localparam int              NT  = 1100;
  localparam logic [W-1:0]    FIX = 64'h0123_4567_89AB_CDEF;

  logic           clk  = 1'b0;
  logic           rst  = 1'b1;
  logic           run  = 1'b0;
  logic [2:0]     mode = 3'd0;
  logic           enable;
  logic           busy;
  logic [W-1:0]   data_in;
  logic [15:0]    frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] lfsr_tab [0:NT-1];

  led_test_pattern_gen #(
    .DATA_W(W), .PERIOD(P), .FIXED_PATTERN(FIX), .LFSR_SEED(32'h0000_0001)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode),
    .enable(enable), .data_in(data_in), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of data advances seen after n cycles in RUN: one per completed strobe.
  function automatic int adv(input int n);
    return (n == 0) ? 0 : (n - 1) / P;
  endfunction

  // Frame expected after a advances from the seed of mode m.
  function automatic logic [W-1:0] exp_frame(input logic [2:0] m, input int a);
    logic [W-1:0] v;
    v = '0;
    case (m)
      3'd1:    v = (a % 2 == 0) ? {2{32'h5555_5555}} : {2{32'hAAAA_AAAA}};
      3'd2:    v[a % W] = 1'b1;
      3'd3:    v = {2{32'(a)}};
      3'd4:    v = (a < NT) ? {2{lfsr_tab[a]}} : '0;
      3'd5:    v = (a % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
      default: v = FIX;
    endcase
    return v;
  endfunction

  logic         m_valid   = 1'b0;
  logic         m_active  = 1'b0;
  int           m_n       = 0;
  logic [2:0]   m_mode    = 3'd0;
  logic [W-1:0] m_hold    = FIX;
  logic [15:0]  m_hold_fc = 16'd0;

  // Model: track elapsed RUN cycles; on stop freeze the last frame and count.
  always @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b1;
      m_active  <= 1'b0;
      m_hold    <= FIX;
      m_hold_fc <= 16'd0;
    end else if (!m_active) begin
      if (run) begin
        m_active <= 1'b1;
        m_n      <= 0;
        m_mode   <= mode;
      end
    end else if (!run) begin
      m_active  <= 1'b0;
      m_hold    <= exp_frame(m_mode, adv(m_n));
      m_hold_fc <= 16'(m_n / P);
    end else begin
      m_n <= m_n + 1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_active) begin
        chk("m_enable", W'(enable), W'(m_n > 0 && m_n % P == 0));
        chk("m_busy", W'(busy), W'(1));
        chk("m_frame_cnt", W'(frame_cnt), W'(16'(m_n / P)));
        chk("m_data", data_in, exp_frame(m_mode, adv(m_n)));
      end else begin
        chk("m_enable", W'(enable), W'(0));
        chk("m_busy", W'(busy), W'(0));
        chk("m_frame_cnt", W'(frame_cnt), W'(m_hold_fc));
        chk("m_data", data_in, m_hold);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [31:0] s;
    lfsr_tab[0] = 32'h0000_0001;
    for (int i = 1; i < NT; i++) begin
      s = lfsr_tab[i-1];
      lfsr_tab[i] = s[0] ? ({1'b0, s[31:1]} ^ 32'h8020_0003) : {1'b0, s[31:1]};
    end

    tick(3);
    chk("rst_enable", W'(enable), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_frame_cnt", W'(frame_cnt), W'(0));
    chk("rst_data", data_in, FIX);

    // Fixed pattern, strobes 8 cycles apart
    rst = 1'b0; mode = 3'd0; run = 1'b1;
    tick(1);
    chk("fix_busy", W'(busy), W'(1));
    chk("fix_en0", W'(enable), W'(0));
    tick(7);
    chk("fix_en7", W'(enable), W'(0));
    tick(1);
    chk("fix_en8", W'(enable), W'(1));
    chk("fix_fc1", W'(frame_cnt), W'(1));
    tick(8);
    chk("fix_fc2", W'(frame_cnt), W'(2));
    tick(8);
    chk("fix_en24", W'(enable), W'(1));
    chk("fix_fc3", W'(frame_cnt), W'(3));
    chk("fix_data", data_in, FIX);
    run = 1'b0;
    tick(2);
    chk("stop_busy", W'(busy), W'(0));
    chk("stop_fc", W'(frame_cnt), W'(3));

    // Walking one; mode change mid-run must be ignored
    mode = 3'd2; run = 1'b1;
    tick(1);
    mode = 3'd5;
    tick(8);  chk("walk0", data_in, 64'h1);
    tick(8);  chk("walk1", data_in, 64'h2);
    tick(8);  chk("walk2", data_in, 64'h4);
    tick(8 * 61); chk("walk63", data_in, 64'h8000_0000_0000_0000);
    tick(8);  chk("walk64", data_in, 64'h1);
    run = 1'b0;
    tick(2);

    // Alternate, then ramp
    mode = 3'd1; run = 1'b1;
    tick(1);
    tick(8); chk("alt0", data_in, {2{32'h5555_5555}});
    tick(8); chk("alt1", data_in, {2{32'hAAAA_AAAA}});
    tick(8); chk("alt2", data_in, {2{32'h5555_5555}});
    run = 1'b0;
    tick(2);
    mode = 3'd3; run = 1'b1;
    tick(1);
    tick(8); chk("ramp0", data_in, 64'h0);
    tick(8); chk("ramp1", data_in, {2{32'h0000_0001}});
    tick(8); chk("ramp2", data_in, {2{32'h0000_0002}});
    run = 1'b0;
    tick(2);

    // LFSR from seed 1, then a long run under the model
    mode = 3'd4; run = 1'b1;
    tick(1);
    tick(8); chk("lfsr0", data_in, {2{32'h0000_0001}});
    tick(8); chk("lfsr1", data_in, {2{32'h8020_0003}});
    tick(8); chk("lfsr2", data_in, {2{32'hC030_0002}});
    tick(8 * 1000);
    run = 1'b0;
    tick(2);

    // Reset mid-frame at counter 5
    mode = 3'd3; run = 1'b1;
    tick(1);
    tick(21);
    rst = 1'b1; run = 1'b0;
    tick(1);
    chk("rst_mid_en", W'(enable), W'(0));
    chk("rst_mid_busy", W'(busy), W'(0));
    chk("rst_mid_data", data_in, FIX);
    chk("rst_mid_fc", W'(frame_cnt), W'(0));
    rst = 1'b0;
    tick(2);

    // run drops on the strobe cycle, re-enters one cycle later in blink mode
    mode = 3'd1; run = 1'b1;
    tick(1);
    tick(8);
    chk("drop_strobe", W'(enable), W'(1));
    run = 1'b0;
    tick(1);
    chk("drop_en", W'(enable), W'(0));
    chk("drop_busy", W'(busy), W'(0));
    chk("drop_data", data_in, {2{32'h5555_5555}});
    chk("drop_fc", W'(frame_cnt), W'(1));
    mode = 3'd5; run = 1'b1;
    tick(1);
    chk("re_busy", W'(busy), W'(1));
    chk("re_data", data_in, {W{1'b1}});
    chk("re_fc", W'(frame_cnt), W'(0));
    tick(7);
    chk("re_en7", W'(enable), W'(0));
    tick(1);
    chk("re_en8", W'(enable), W'(1));
    chk("re_data8", data_in, {W{1'b1}});
    tick(1);
    chk("re_data9", data_in, {W{1'b0}});
    run = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
